// File: rtl/logic_reduce_pkg.sv
// Shared types for the multi-beat bitwise reduction unit: operator and state
// encodings, plus helpers that map a requested mode to its base fold operator.
package logic_reduce_pkg;

   typedef enum logic [2:0] {
      MODE_AND  = 3'd0,
      MODE_OR   = 3'd1,
      MODE_XOR  = 3'd2,
      MODE_NAND = 3'd3,
      MODE_NOR  = 3'd4,
      MODE_XNOR = 3'd5
   } mode_e;

   typedef enum logic [1:0] {
      OP_AND = 2'd0,
      OP_OR  = 2'd1,
      OP_XOR = 2'd2
   } base_op_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_e;

   function automatic logic is_inverting(input mode_e m);
      return (m == MODE_NAND) || (m == MODE_NOR) || (m == MODE_XNOR);
   endfunction

   function automatic logic is_legal(input logic [2:0] m);
      return m <= 3'd5;
   endfunction

   // Inverting modes fold with the same operator as their plain counterpart;
   // the inversion is applied only when presenting the result.
   function automatic base_op_e base_op(input mode_e m);
      base_op_e op;
      op = OP_AND;
      case (m)
         MODE_OR,  MODE_NOR:  op = OP_OR;
         MODE_XOR, MODE_XNOR: op = OP_XOR;
         default:             op = OP_AND;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/logic_reduce_op.sv
// Combinational WIDTH-bit bitwise operator, a op b, for the base operators
// AND, OR and XOR.
module logic_reduce_op
   import logic_reduce_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  base_op_e         op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] y
);

   always_comb begin
      y = a & b;
      case (op)
         OP_OR:   y = a | b;
         OP_XOR:  y = a ^ b;
         default: y = a & b;
      endcase
   end

endmodule

// File: rtl/logic_reduce_acc.sv
// Multi-beat bitwise reduction: folds a packet of words with a selectable
// operator and holds one result word plus a single-bit reduction until taken.
module logic_reduce_acc
   import logic_reduce_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int MAX_BEATS = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [2:0]       mode,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_bit,
   output logic [$clog2(MAX_BEATS+1)-1:0] out_count,
   output logic             out_err
);

   localparam int CNT_W = $clog2(MAX_BEATS+1);
   localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(MAX_BEATS - 1);

   state_e           state;
   logic [WIDTH-1:0] acc;
   logic [CNT_W-1:0] count;
   mode_e            mode_q;
   logic             err_q;
   logic [WIDTH-1:0] fold;
   logic             beat;
   logic             inv;
   logic             base_bit;

   assign in_ready  = (state != HOLD);
   assign out_valid = (state == HOLD);
   assign beat      = in_valid && in_ready;

   logic_reduce_op #(.WIDTH(WIDTH)) u_op (
      .op (base_op(mode_q)),
      .a  (acc),
      .b  (in_data),
      .y  (fold)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         acc    <= '0;
         count  <= '0;
         mode_q <= MODE_AND;
         err_q  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (beat) begin
                  acc   <= in_data;
                  count <= CNT_W'(1);
                  // Illegal modes fall back to AND and flag the packet.
                  if (is_legal(mode)) begin
                     mode_q <= mode_e'(mode);
                  end else begin
                     mode_q <= MODE_AND;
                     err_q  <= 1'b1;
                  end
                  state <= in_last ? HOLD : ACCUM;
               end
            end
            ACCUM: begin
               if (beat) begin
                  acc   <= fold;
                  count <= count + CNT_W'(1);
                  if (in_last) begin
                     state <= HOLD;
                  end else if (count == LAST_COUNT) begin
                     state <= HOLD;
                     err_q <= 1'b1;
                  end
               end
            end
            HOLD: begin
               if (out_ready) begin
                  state <= IDLE;
                  err_q <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Result outputs are decoded purely from registered state.
   always_comb begin
      inv      = is_inverting(mode_q);
      base_bit = &acc;
      case (base_op(mode_q))
         OP_OR:   base_bit = |acc;
         OP_XOR:  base_bit = ^acc;
         default: base_bit = &acc;
      endcase
      out_data  = inv ? ~acc : acc;
      out_bit   = base_bit ^ inv;
      out_count = count;
      out_err   = err_q;
   end

endmodule

// File: tb/tb_logic_reduce_acc.sv
// Directed self-checking bench for logic_reduce_acc with hand-computed
// expected results for each packet scenario.
module tb_logic_reduce_acc;

   localparam int WIDTH     = 8;
   localparam int MAX_BEATS = 16;
   localparam int CNT_W     = $clog2(MAX_BEATS+1);

   logic             clk;
   logic             rst;
   logic [2:0]       mode;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_bit;
   logic [CNT_W-1:0] out_count;
   logic             out_err;

   int errors;
   int checks;

   logic_reduce_acc #(.WIDTH(WIDTH), .MAX_BEATS(MAX_BEATS)) dut (
      .clk       (clk),
      .rst       (rst),
      .mode      (mode),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_bit   (out_bit),
      .out_count (out_count),
      .out_err   (out_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Presents one beat, waits (bounded) for in_ready, and returns #1 after the accepting edge.
   task automatic applyStimulus(input logic [2:0] m, input logic [7:0] d, input logic last);
      int waited;
      mode     = m;
      in_data  = d;
      in_last  = last;
      in_valid = 1'b1;
      waited   = 0;
      while (!in_ready && waited < 50) begin
         @(posedge clk);
         #1;
         waited++;
      end
      if (!in_ready) checkOutput("beat_accept_timeout", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic takeResult();
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   task automatic checkResult(input string tag, input logic [7:0] d, input logic b,
                              input logic [CNT_W-1:0] c, input logic e);
      checkOutput({tag, "_valid"}, 32'(out_valid), 32'd1);
      checkOutput({tag, "_data"},  32'(out_data),  32'(d));
      checkOutput({tag, "_bit"},   32'(out_bit),   32'(b));
      checkOutput({tag, "_count"}, 32'(out_count), 32'(c));
      checkOutput({tag, "_err"},   32'(out_err),   32'(e));
   endtask

   initial begin
      errors    = 0;
      checks    = 0;
      rst       = 1'b1;
      mode      = 3'd0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_last   = 1'b0;
      out_ready = 1'b0;
      #12;
      rst = 1'b0;
      @(posedge clk);
      #1;

      checkOutput("reset_valid", 32'(out_valid), 32'd0);
      checkOutput("reset_ready", 32'(in_ready),  32'd1);
      checkOutput("reset_data",  32'(out_data),  32'd0);
      checkOutput("reset_bit",   32'(out_bit),   32'd0);
      checkOutput("reset_count", 32'(out_count), 32'd0);
      checkOutput("reset_err",   32'(out_err),   32'd0);

      // out_ready outside HOLD must have no effect
      takeResult();
      checkOutput("stray_ready_valid", 32'(out_valid), 32'd0);

      // AND over three beats; result valid on the edge that takes the last beat
      applyStimulus(3'd0, 8'hFF, 1'b0);
      checkOutput("and_mid_valid", 32'(out_valid), 32'd0);
      applyStimulus(3'd0, 8'hF0, 1'b0);
      applyStimulus(3'd0, 8'h3C, 1'b1);
      checkResult("and3", 8'h30, 1'b0, 5'd3, 1'b0);
      checkOutput("and3_hold_ready", 32'(in_ready), 32'd0);
      takeResult();
      checkOutput("and3_after_valid", 32'(out_valid), 32'd0);
      checkOutput("and3_after_ready", 32'(in_ready),  32'd1);

      // XNOR with an idle gap mid-packet
      applyStimulus(3'd5, 8'h0F, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("xnor_gap_valid", 32'(out_valid), 32'd0);
      applyStimulus(3'd2, 8'h01, 1'b1);
      checkResult("xnor2", 8'hF1, 1'b0, 5'd2, 1'b0);
      takeResult();

      // Single-beat NOR held under back-pressure
      applyStimulus(3'd4, 8'h00, 1'b1);
      checkResult("nor1", 8'hFF, 1'b1, 5'd1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         checkOutput("nor1_stall_ready", 32'(in_ready), 32'd0);
         checkOutput("nor1_stall_data",  32'(out_data), 32'hFF);
      end
      takeResult();

      // OR force-closed at MAX_BEATS without in_last
      for (int i = 0; i < MAX_BEATS; i++) begin
         applyStimulus(3'd1, 8'h01, 1'b0);
         if (i == MAX_BEATS - 2) checkOutput("or16_pre_valid", 32'(out_valid), 32'd0);
      end
      checkResult("or16", 8'h01, 1'b1, 5'd16, 1'b1);
      mode     = 3'd1;
      in_data  = 8'h80;
      in_valid = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("or16_stall_ready", 32'(in_ready),  32'd0);
      checkOutput("or16_stall_count", 32'(out_count), 32'd16);
      checkOutput("or16_stall_data",  32'(out_data),  32'h01);
      in_valid = 1'b0;
      takeResult();

      // Illegal mode 7 folds as AND and flags the packet; next packet is clean
      applyStimulus(3'd7, 8'hAA, 1'b0);
      applyStimulus(3'd1, 8'h0F, 1'b1);
      checkResult("ill", 8'h0A, 1'b0, 5'd2, 1'b1);
      takeResult();
      applyStimulus(3'd1, 8'h12, 1'b0);
      applyStimulus(3'd1, 8'h21, 1'b1);
      checkResult("or2", 8'h33, 1'b1, 5'd2, 1'b0);
      takeResult();

      // Reset mid-packet discards the partial fold
      applyStimulus(3'd2, 8'hC3, 1'b0);
      applyStimulus(3'd2, 8'h11, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("rst_mid_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_mid_count", 32'(out_count), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      checkOutput("rst_mid_ready", 32'(in_ready), 32'd1);
      applyStimulus(3'd2, 8'h55, 1'b0);
      applyStimulus(3'd0, 8'hFF, 1'b1);
      checkResult("xor_after_rst", 8'hAA, 1'b0, 5'd2, 1'b0);
      takeResult();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
